exe_mdu_ctrl: RTL and testbench

- Sequencer for an iterative multiply/divide unit that sits alongside the execute-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from execute, runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles, and holds the pipeline through stall_req until HI/LO are valid.
- Single-cycle ALU ops never pass through this block. The existing ALU_MUL path stays combinational for the low-word-only MUL.

---
 rtl/exe_mdu_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_exe_mdu_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_mdu_ctrl.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply, restoring divide, HI/LO result.
// Optional macro MDU_EARLY_OUT_EN: multiply exits CALC once the remaining multiplier bits are zero.
module exe_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             mdu_i_start,
  input  logic [1:0]       mdu_i_op,
  input  logic [WIDTH-1:0] mdu_i_src1,
  input  logic [WIDTH-1:0] mdu_i_src2,
  input  logic             mdu_i_flush,
  output logic             mdu_o_stall_req,
  output logic             mdu_o_busy,
  output logic             mdu_o_done,
  output logic [WIDTH-1:0] mdu_o_hi,
  output logic [WIDTH-1:0] mdu_o_lo,
  output logic             mdu_o_dbz
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [1:0]       op_q, op_d;
  logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic             start_ok, in_signed, is_div, is_signed;
  logic [WIDTH-1:0] abs1, abs2, quo_fix, rem_fix;
  logic [WIDTH:0]   sum, shl, trial;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  assign start_ok  = mdu_i_start & ~mdu_i_flush;
  assign in_signed = ~mdu_i_op[0];
  assign abs1      = (in_signed & mdu_i_src1[WIDTH-1]) ? neg_w(mdu_i_src1) : mdu_i_src1;
  assign abs2      = (in_signed & mdu_i_src2[WIDTH-1]) ? neg_w(mdu_i_src2) : mdu_i_src2;
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // One iteration of each algorithm; acc/low/opb are shared between multiply and divide.
  assign sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
  assign shl   = {acc_q, low_q[WIDTH-1]};
  assign trial = shl - {1'b0, opb_q};

  always_comb begin
    prod = {acc_q, low_q};
`ifdef MDU_EARLY_OUT_EN
    prod = prod >> (WIDTH - int'(cnt_q));
`endif
    if (is_signed & quo_neg_q) prod = neg_2w(prod);
    quo_fix = (is_signed & quo_neg_q) ? neg_w(low_q) : low_q;
    rem_fix = (is_signed & rem_neg_q) ? neg_w(acc_q) : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opb_d     = opb_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d      = mdu_i_op;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          quo_neg_d = in_signed & (mdu_i_src1[WIDTH-1] ^ mdu_i_src2[WIDTH-1]);
          rem_neg_d = in_signed & mdu_i_src1[WIDTH-1];
          acc_d     = '0;
          if (mdu_i_op[1] && mdu_i_src2 == '0) begin
            state_d = S_DONE;
            lo_d    = '1;
            hi_d    = mdu_i_src1;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else if (mdu_i_op[1]) begin
            state_d = S_CALC;
            low_d   = abs1;
            opb_d   = abs2;
          end else begin
            state_d = S_CALC;
            low_d   = abs2;
            opb_d   = abs1;
          end
        end
      end
      S_CALC: begin
        if (mdu_i_flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
          if (is_div) begin
            if (!trial[WIDTH]) begin
              acc_d = trial[WIDTH-1:0];
              low_d = {low_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = shl[WIDTH-1:0];
              low_d = {low_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = sum[WIDTH:1];
            low_d = {sum[0], low_q[WIDTH-1:1]};
          end
`ifdef MDU_EARLY_OUT_EN
          // Remaining multiplier bits sit in the low WIDTH-cnt bits of low_q.
          if (!is_div && (low_q << cnt_q) == '0) begin
            acc_d   = acc_q;
            low_d   = low_q;
            cnt_d   = cnt_q;
            state_d = S_FIX;
          end
`endif
        end
      end
      S_FIX: begin
        if (mdu_i_flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod;
          end
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  // Stall drops in DONE so the stalled instruction retires with HI/LO visible.
  assign mdu_o_stall_req = ((state_q == S_IDLE) & start_ok) | (state_q == S_CALC) | (state_q == S_FIX);
  assign mdu_o_busy      = (state_q != S_IDLE);
  assign mdu_o_done      = done_q;
  assign mdu_o_hi        = hi_q;
  assign mdu_o_lo        = lo_q;
  assign mdu_o_dbz       = dbz_q;
endmodule

// File: tb/tb_exe_mdu_ctrl.sv
// Self-checking bench for exe_mdu_ctrl: directed cases plus random ops against an arithmetic model.
module tb_exe_mdu_ctrl;
  localparam int W = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst = 1'b1;
  logic          mdu_i_start = 1'b0;
  logic [1:0]    mdu_i_op = 2'b00;
  logic [W-1:0]  mdu_i_src1 = '0;
  logic [W-1:0]  mdu_i_src2 = '0;
  logic          mdu_i_flush = 1'b0;
  logic          mdu_o_stall_req, mdu_o_busy, mdu_o_done, mdu_o_dbz;
  logic [W-1:0]  mdu_o_hi, mdu_o_lo;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] ref_hi = '0, ref_lo = '0;
  logic         ref_dbz = 1'b0;

  exe_mdu_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .mdu_i_start(mdu_i_start), .mdu_i_op(mdu_i_op),
    .mdu_i_src1(mdu_i_src1), .mdu_i_src2(mdu_i_src2), .mdu_i_flush(mdu_i_flush),
    .mdu_o_stall_req(mdu_o_stall_req), .mdu_o_busy(mdu_o_busy), .mdu_o_done(mdu_o_done),
    .mdu_o_hi(mdu_o_hi), .mdu_o_lo(mdu_o_lo), .mdu_o_dbz(mdu_o_dbz)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: HI/LO from plain arithmetic, latency from the iteration-count rules.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edbz,
                       output int elat);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [W-1:0] m;
    int k;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edbz = 1'b0;
    elat = W + 2;
    if (op[1] && b == 0) begin
      eh = a; el = '1; edbz = 1'b1; elat = 1;
    end else if (op == 2'b10) begin
      q = sa / sb; r = sa % sb;
      el = q[W-1:0]; eh = r[W-1:0];
    end else if (op == 2'b11) begin
      el = a / b; eh = a % b;
    end else begin
      if (op == 2'b00) p = 64'(sa * sb);
      else             p = {32'b0, a} * {32'b0, b};
      {eh, el} = p;
      m = (op == 2'b00 && b[W-1]) ? -b : b;
      k = 0;
      for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
`ifdef MDU_EARLY_OUT_EN
      if (k < W) elat = k + 3;
`endif
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit hammer);
    logic [W-1:0] eh, el;
    logic edbz;
    int elat, lat, stalls;
    model(op, a, b, eh, el, edbz, elat);
    mdu_i_op = op; mdu_i_src1 = a; mdu_i_src2 = b; mdu_i_start = 1'b1; mdu_i_flush = 1'b0;
    #1;
    check({tag, "_stall_on_start"}, 64'(mdu_o_stall_req), 64'd1);
    step();
    mdu_i_start = hammer;
    if (hammer) begin
      mdu_i_op = 2'($urandom); mdu_i_src1 = $urandom; mdu_i_src2 = $urandom;
    end
    lat = 0;
    stalls = 0;
    for (int n = 1; n <= 100; n++) begin
      if (mdu_o_done) begin
        lat = n;
        break;
      end
      if (mdu_o_stall_req) stalls++;
      step();
    end
    mdu_i_start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(elat - 1));
    check({tag, "_hi"}, 64'(mdu_o_hi), 64'(eh));
    check({tag, "_lo"}, 64'(mdu_o_lo), 64'(el));
    check({tag, "_dbz"}, 64'(mdu_o_dbz), 64'(edbz));
    step();
    check({tag, "_done_pulse"}, 64'(mdu_o_done), 64'd0);
    check({tag, "_idle_after"}, 64'(mdu_o_busy), 64'd0);
    ref_hi = eh; ref_lo = el; ref_dbz = edbz;
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_hi", 64'(mdu_o_hi), 64'd0);
    check("rst_lo", 64'(mdu_o_lo), 64'd0);
    check("rst_done", 64'(mdu_o_done), 64'd0);
    check("rst_busy", 64'(mdu_o_busy), 64'd0);
    check("rst_stall", 64'(mdu_o_stall_req), 64'd0);
    cpu_rst = 1'b0;
    step();

    run_op("multu_ff_x2", 2'b01, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("multu_ff_x2_hi_lit", 64'(mdu_o_hi), 64'h1);
    check("multu_ff_x2_lo_lit", 64'(mdu_o_lo), 64'hFFFFFFFE);
    run_op("mult_m3_x5", 2'b00, 32'hFFFFFFFD, 32'h5, 1'b0);
    check("mult_m3_x5_lo_lit", 64'(mdu_o_lo), 64'hFFFFFFF1);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h2, 1'b0);
    check("div_m7_2_lo_lit", 64'(mdu_o_lo), 64'hFFFFFFFD);
    check("div_m7_2_hi_lit", 64'(mdu_o_hi), 64'hFFFFFFFF);
    run_op("divu_100_0", 2'b11, 32'd100, 32'd0, 1'b0);
    check("divu_100_0_hi_lit", 64'(mdu_o_hi), 64'd100);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
    check("divu_100_7_lo_lit", 64'(mdu_o_lo), 64'd14);
    check("divu_100_7_hi_lit", 64'(mdu_o_hi), 64'd2);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo_lit", 64'(mdu_o_lo), 64'h80000000);

    // Flush during CALC: results untouched, a fresh start goes straight in
    mdu_i_op = 2'b01; mdu_i_src1 = 32'd6; mdu_i_src2 = 32'd7; mdu_i_start = 1'b1;
    step();
    mdu_i_start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("flush_busy_before", 64'(mdu_o_busy), 64'd1);
    mdu_i_flush = 1'b1;
    step();
    mdu_i_flush = 1'b0;
    check("flush_busy", 64'(mdu_o_busy), 64'd0);
    check("flush_done", 64'(mdu_o_done), 64'd0);
    check("flush_hi", 64'(mdu_o_hi), 64'(ref_hi));
    check("flush_lo", 64'(mdu_o_lo), 64'(ref_lo));
    run_op("after_flush", 2'b01, 32'd6, 32'd7, 1'b0);

    // Start and flush together in IDLE: dropped
    mdu_i_op = 2'b11; mdu_i_src1 = 32'd9; mdu_i_src2 = 32'd0;
    mdu_i_start = 1'b1; mdu_i_flush = 1'b1;
    #1;
    check("start_flush_stall", 64'(mdu_o_stall_req), 64'd0);
    step();
    mdu_i_start = 1'b0; mdu_i_flush = 1'b0;
    check("start_flush_busy", 64'(mdu_o_busy), 64'd0);
    check("start_flush_done", 64'(mdu_o_done), 64'd0);
    check("start_flush_lo", 64'(mdu_o_lo), 64'(ref_lo));

    // Start held high while busy must not disturb the running op
    run_op("hammer_mult", 2'b00, 32'h12345, 32'hFFFF0003, 1'b1);
    run_op("hammer_div", 2'b10, 32'h7FFFFFF1, 32'hFFFFFFF3, 1'b1);

    // Reset mid-divide
    mdu_i_op = 2'b10; mdu_i_src1 = 32'd1000; mdu_i_src2 = 32'd3; mdu_i_start = 1'b1;
    step();
    mdu_i_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
    check("midrst_hi", 64'(mdu_o_hi), 64'd0);
    check("midrst_lo", 64'(mdu_o_lo), 64'd0);
    check("midrst_busy", 64'(mdu_o_busy), 64'd0);
    check("midrst_done", 64'(mdu_o_done), 64'd0);
    check("midrst_dbz", 64'(mdu_o_dbz), 64'd0);
    step();
    check("midrst_no_done", 64'(mdu_o_done), 64'd0);

`ifdef MDU_EARLY_OUT_EN
    run_op("early_multu", 2'b01, 32'h12345678, 32'd3, 1'b0);
    check("early_multu_lo_lit", 64'(mdu_o_lo), 64'h369D0368);
    run_op("early_zero", 2'b00, 32'hDEADBEEF, 32'd0, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 15);
        2: rb = 32'd0;
        default: rb = 32'hFFFFFFFF;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
